// File: rtl/sp_bram_param_if.sv
// sp_bram_param_if: port bundle for the single-port block RAM.
`default_nettype none

interface sp_bram_param_if #(
  parameter int DATA_WIDTH = 32
);
  logic                      ena;
  logic [DATA_WIDTH/8-1:0]   wea;
  logic [31:0]               addra;
  logic [DATA_WIDTH-1:0]     dina;
  logic [DATA_WIDTH-1:0]     douta;
  logic                      douta_valid;

  modport master (
    output ena, wea, addra, dina,
    input  douta, douta_valid
  );

  modport slave (
    input  ena, wea, addra, dina,
    output douta, douta_valid
  );
endinterface

`default_nettype wire

// File: rtl/sp_bram_param.sv
// sp_bram_param: byte-addressed single-port BRAM with byte enables,
// 1/2-cycle read latency, selectable read-during-write mode and a valid strobe.
`default_nettype none

module sp_bram_param #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    DEPTH        = 1024,
  parameter int                    READ_LATENCY = 1,
  parameter int                    WRITE_MODE   = 0,
  parameter logic [DATA_WIDTH-1:0] RST_VALUE    = '0
) (
  input  logic              clka,
  input  logic              rsta,
  sp_bram_param_if.slave    bus
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int BL = $clog2(NB);
  localparam int AW = $clog2(DEPTH);

  generate
    if (!(READ_LATENCY == 1 || READ_LATENCY == 2) || WRITE_MODE < 0 || WRITE_MODE > 2 ||
        (DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8 || DATA_WIDTH > 256 ||
        DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
      $error("sp_bram_param: illegal parameter set");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  logic [AW-1:0]         idx;
  logic                  is_write;
  logic                  load;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  unused_addr;

  // Byte-offset and upper address bits only alias; fold them into a dummy.
  assign unused_addr = ^bus.addra;
  assign idx         = bus.addra[BL +: AW];
  assign is_write    = |bus.wea;
  assign load        = bus.ena && (!is_write || WRITE_MODE != 2);

  always_comb begin
    rd_word = mem[idx];
    merged  = rd_word;
    for (int i = 0; i < NB; i++) begin
      if (bus.wea[i]) merged[8*i +: 8] = bus.dina[8*i +: 8];
    end
    ld_data = (is_write && WRITE_MODE == 0) ? merged : rd_word;
  end

  // Array is not reset, so writes in a reset cycle still land.
  always_ff @(posedge clka) begin
    if (bus.ena) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.wea[i]) mem[idx][8*i +: 8] <= bus.dina[8*i +: 8];
      end
    end
  end

  logic [DATA_WIDTH-1:0] q1 = RST_VALUE;
  logic                  v1 = 1'b0;

  always_ff @(posedge clka) begin
    if (rsta) begin
      q1 <= RST_VALUE;
      v1 <= 1'b0;
    end else begin
      v1 <= load;
      if (load) q1 <= ld_data;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] q2 = RST_VALUE;
      logic                  v2 = 1'b0;

      always_ff @(posedge clka) begin
        if (rsta) begin
          q2 <= RST_VALUE;
          v2 <= 1'b0;
        end else begin
          q2 <= q1;
          v2 <= v1;
        end
      end

      assign bus.douta       = q2;
      assign bus.douta_valid = v2;
    end else begin : g_lat1
      assign bus.douta       = q1;
      assign bus.douta_valid = v1;
    end
  endgenerate
endmodule

`default_nettype wire

// File: doc/sp_bram_param.md
Name: sp_bram_param

Overview:
- Parametrised single-port block RAM with per-byte write enables, selectable read latency and selectable read-during-write mode.
- Successor to the fixed 32-bit single-port memory instance in the block design.
- Byte-addressed so it sits directly behind the BRAM-controller address bus.
- Adds a read-data valid strobe so downstream logic does not count cycles.

Parameters:
DATA_WIDTH, 32, word width in bits; multiple of 8, range 8..256
DEPTH, 1024, number of words; power of two, >= 2
READ_LATENCY, 1, cycles from accepted op to douta update; 1 or 2 only
WRITE_MODE, 0, read-during-write: 0 = WRITE_FIRST, 1 = READ_FIRST, 2 = NO_CHANGE
RST_VALUE, 0, value loaded into douta by reset (DATA_WIDTH bits)

Ports:
clka  in  1  clock; all logic on rising edge
rsta  in  1  synchronous, active-high reset; output path only
ena  in  1  port enable; no op is accepted when low
wea  in  DATA_WIDTH/8  byte write enables; bit i covers dina[8i+7:8i]
addra  in  32  byte address
dina  in  DATA_WIDTH  write data
douta  out  DATA_WIDTH  read data
douta_valid  out  1  one-cycle strobe; douta updated this cycle

Behaviour:
- Decided interface facts:
  - Single clock: clka.
  - Reset rsta is synchronous and active-high.
- Addressing:
  - BL = log2(DATA_WIDTH/8), AW = log2(DEPTH).
  - Word index = addra[BL+AW-1:BL].
  - addra[BL-1:0] and addra[31:BL+AW] are ignored, so the address space aliases and wraps modulo DEPTH words.
- Operation types, sampled at rising clka:
  - Read: ena=1, wea=0.
  - Write: ena=1, wea!=0.
  - Idle: ena=0; wea and dina are ignored.
- Write:
  - For each byte i with wea[i]=1, mem[idx] byte i takes the dina byte.
  - Other bytes are unchanged.
  - The array is visible to a read on the following cycle.
- Read: stage-1 register captures mem[idx].
- Write, by WRITE_MODE:
  - WRITE_FIRST: stage-1 captures the merged (new) word.
  - READ_FIRST: stage-1 captures the pre-write word.
  - NO_CHANGE: stage-1 is not loaded.
- Latency:
  - READ_LATENCY=1: douta is the stage-1 register. Data is valid in the cycle after the accepted op (the edge after the op edge).
  - READ_LATENCY=2: a second register follows stage 1 and advances every cycle. Data appears one cycle later.
- douta_valid:
  - Pulses high exactly READ_LATENCY cycles after each op that loads stage 1: reads, and writes in modes 0/1.
  - Never asserted for idle cycles or NO_CHANGE writes.
  - Back-to-back ops produce back-to-back strobes. Throughput is one op per cycle.
- Hold: when no load reaches douta, douta holds its last value.
- Reset (rsta=1 at an edge):
  - douta = RST_VALUE, douta_valid = 0.
  - All pipeline stages are cleared, including pending valid bits, so in-flight reads are discarded and produce no strobe after reset deasserts.
  - Memory contents are not cleared.
  - A write presented with ena=1 in a reset cycle still updates the array.
- Power-up:
  - Array is initialised to all zeros in simulation.
  - douta = RST_VALUE and douta_valid = 0 before the first reset.
- Parameter check: illegal values stop elaboration. This covers READ_LATENCY not in {1,2}, WRITE_MODE > 2, DATA_WIDTH % 8 != 0, and DEPTH not a power of 2.

Test Plan:
1. Defaults; reset 10 cycles. Write 0x5555555D at addra=0x0 with wea=0xF, then read at 0x0 -> douta=0x5555555D with douta_valid high exactly 1 cycle after the read edge. Before that, douta=0 and douta_valid=0 throughout reset.
2. Byte enables: write 0xAABBCCDD to addr 0x10, then write 0x11223344 with wea=0x5, then read -> 0xAA22CC44.
3. Modes: mem[0x4]=0x1, then write 0x2 at 0x4:
   - WRITE_MODE=0 -> douta=0x2 with strobe.
   - WRITE_MODE=1 -> douta=0x1 with strobe.
   - WRITE_MODE=2 -> douta keeps its prior value, no strobe.
   - In all three modes, a subsequent read returns 0x2.
4. Aliasing with DEPTH=16: write 0xCAFEF00D at addra=0x3C, then read at 0x7C and at 0x3F -> both return 0xCAFEF00D.
5. READ_LATENCY=2, three back-to-back reads of 0x0/0x4/0x8 holding 0xA/0xB/0xC -> douta shows 0xA, 0xB, 0xC on consecutive cycles starting 2 cycles after the first read edge. douta_valid is high for exactly 3 cycles.
6. READ_LATENCY=2, RST_VALUE=0xDEADBEEF:
   - Issue a read, then assert rsta on the next edge -> douta=0xDEADBEEF and no strobe appears for the discarded read.
   - A write to 0x8 of 0x77 during rsta=1, read after reset -> 0x77.
